// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel generator:
// geometry defaults, mode codes and 24-bit colours.
package vga_pkg;

  localparam int H_DISP   = 1280;
  localparam int V_DISP   = 1024;
  localparam int COLOR_W  = 8;
  localparam int BOX_W    = 64;
  localparam int BOX_H    = 64;
  localparam int SPEED    = 4;
  localparam int CHK_LOG2 = 5;

  localparam logic SYNC_IDLE = 1'b1;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;
  localparam logic [23:0] C_GREY    = 24'h808080;

  // Bar table, left to right across the line
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    c = C_BLACK;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pixel_gen_bounce.sv
// One axis of the bouncing box: steps by SPEED
// on each step pulse, clamping and reversing at 0/LIM.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int LIM   = 1216,
  parameter int SPEED = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [11:0] pos,
  output logic        dir
);

  localparam logic [11:0] LIM_C = 12'(LIM);
  localparam logic [11:0] SPD_C = 12'(SPEED);

  logic [12:0] fwd;

  assign fwd = {1'b0, pos} + {1'b0, SPD_C};

  // dir=0 moves towards LIM, dir=1 moves towards 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
      dir <= 1'b0;
    end else if (step) begin
      if (!dir) begin
        if (fwd >= {1'b0, LIM_C}) begin
          pos <= LIM_C;
          dir <= 1'b1;
        end else begin
          pos <= fwd[11:0];
        end
      end else begin
        if (pos <= SPD_C) begin
          pos <= '0;
          dir <= 1'b0;
        end else begin
          pos <= pos - SPD_C;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pixel_gen.sv
// Test-pattern pixel source for the ADV7123 DAC.
// Two-stage pipeline; sync/blank delayed to match.
module vga_pixel_gen
  import vga_pkg::*;
#(
  parameter int H_DISP_P   = H_DISP,
  parameter int V_DISP_P   = V_DISP,
  parameter int BOX_W_P    = BOX_W,
  parameter int BOX_H_P    = BOX_H,
  parameter int SPEED_P    = SPEED,
  parameter int CHK_LOG2_P = CHK_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            xpix,
  input  logic [31:0]            ypix,
  input  logic                   disp_enable,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  input  logic                   freeze,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   blank_n_o,
  output logic                   sync_n_o,
  output logic                   frame_tick
);

  logic [10:0] x, y;
  logic        unused_bits;

  assign x = xpix[10:0];
  assign y = ypix[10:0];
  assign unused_bits = ^{xpix[31:11], ypix[31:11]};

  logic [11:0] bx, by;
  logic        bx_dir, by_dir;
  logic        vs_q;
  logic        step;
  mode_e       mode_act;
  logic [23:0] solid_act;

  assign step     = frame_tick & ~freeze;
  assign sync_n_o = 1'b0;

  bounce_axis #(
    .LIM   (H_DISP_P - BOX_W_P),
    .SPEED (SPEED_P)
  ) u_bx (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .pos  (bx),
    .dir  (bx_dir)
  );

  bounce_axis #(
    .LIM   (V_DISP_P - BOX_H_P),
    .SPEED (SPEED_P)
  ) u_by (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .pos  (by),
    .dir  (by_dir)
  );

  logic unused_dir;
  assign unused_dir = bx_dir ^ by_dir;

  // Frame start: vsync_in leaving its idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q       <= SYNC_IDLE;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vsync_in;
      frame_tick <= (vs_q == SYNC_IDLE) &&
                    (vsync_in != SYNC_IDLE);
    end
  end

  // Mode and solid colour only change at frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_act  <= MODE_BARS;
      solid_act <= '0;
    end else if (frame_tick) begin
      mode_act  <= mode_e'(mode);
      solid_act <= solid_rgb;
    end
  end

  logic [2:0] bar_c;
  logic       chk_c;
  logic       box_c;
  logic [11:0] xw, yw;

  assign xw = {1'b0, x};
  assign yw = {1'b0, y};

  // Region flags from the raw coordinates; bar index via constant compares
  always_comb begin
    bar_c = '0;
    for (int k = 1; k < 8; k++) begin
      if (xw >= 12'(H_DISP_P * k / 8)) bar_c = bar_c + 3'd1;
    end
    chk_c = x[CHK_LOG2_P] ^ y[CHK_LOG2_P];
    box_c = (xw >= bx) && (xw < bx + 12'(BOX_W_P)) &&
            (yw >= by) && (yw < by + 12'(BOX_H_P));
  end

  logic       de1, hs1, vs1;
  logic [2:0] bar1;
  logic       chk1, box1;

  // Stage 1: flags and timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de1  <= 1'b0;
      hs1  <= SYNC_IDLE;
      vs1  <= SYNC_IDLE;
      bar1 <= '0;
      chk1 <= 1'b0;
      box1 <= 1'b0;
    end else begin
      de1  <= disp_enable;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
      bar1 <= bar_c;
      chk1 <= chk_c;
      box1 <= box_c;
    end
  end

  logic [23:0] col;

  // Pattern select; blanked pixels are forced black
  always_comb begin
    col = '0;
    unique case (mode_act)
      MODE_BARS:  col = bar_color(bar1);
      MODE_CHECK: col = chk1 ? C_WHITE : C_BLACK;
      MODE_BOX:   col = box1 ? C_RED : C_GREY;
      MODE_SOLID: col = solid_act;
    endcase
    if (!de1) col = '0;
  end

  // Stage 2: registered colour and delayed timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      hsync_o   <= SYNC_IDLE;
      vsync_o   <= SYNC_IDLE;
      blank_n_o <= 1'b0;
    end else begin
      vga_r     <= col[23:16];
      vga_g     <= col[15:8];
      vga_b     <= col[7:0];
      hsync_o   <= hs1;
      vsync_o   <= vs1;
      blank_n_o <= de1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Self-checking bench for vga_pixel_gen against
// a behavioural model of patterns and box motion.
module tb_vga_pixel_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] xpix, ypix;
  logic        disp_enable, hsync_in, vsync_in;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic        freeze;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        hsync_o, vsync_o, blank_n_o, sync_n_o, frame_tick;

  vga_pixel_gen dut (
    .clk         (clk),
    .rst         (rst),
    .xpix        (xpix),
    .ypix        (ypix),
    .disp_enable (disp_enable),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .freeze      (freeze),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o),
    .blank_n_o   (blank_n_o),
    .sync_n_o    (sync_n_o),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  int          n_moves;
  int          m_mode;
  logic [23:0] m_solid;
  logic [26:0] hist[$];

  localparam logic [26:0] IDLE = {24'h0, 1'b1, 1'b1, 1'b0};

  function automatic int tri_pos(int k, int lim);
    int t;
    t = (4 * k) % (2 * lim);
    return (t <= lim) ? t : 2 * lim - t;
  endfunction

  function automatic int box_x();
    return tri_pos(n_moves, 1280 - 64);
  endfunction

  function automatic int box_y();
    return tri_pos(n_moves, 1024 - 64);
  endfunction

  function automatic logic [23:0] exp_rgb(int x, int y, bit de);
    logic [23:0] bars [8];
    int bx, by, bi;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    if (!de) return 24'h0;
    bx = box_x();
    by = box_y();
    case (m_mode)
      0: begin
        bi = (x >= 1280) ? 7 : x / 160;
        return bars[bi];
      end
      1: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      2: return (x >= bx && x < bx + 64 && y >= by && y < by + 64)
                ? 24'hFF0000 : 24'h808080;
      default: return m_solid;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive, record expectation, check output of 2 cycles ago
  task automatic step(input int x, input int y, input bit de,
                      input bit hs, input bit vs);
    xpix        = ($urandom() << 11) | (32'(x) & 32'h7FF);
    ypix        = ($urandom() << 11) | (32'(y) & 32'h7FF);
    disp_enable = de;
    hsync_in    = hs;
    vsync_in    = vs;
    @(posedge clk);
    hist.push_back({exp_rgb(x, y, de), hs, vs, de});
    #1;
    if (hist.size() >= 2)
      chk("pipe", 32'({vga_r, vga_g, vga_b, hsync_o, vsync_o, blank_n_o}),
          32'(hist[hist.size() - 2]));
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  task automatic frame();
    step(0, 0, 0, 1, 0);
    chk("tick_hi", 32'(frame_tick), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("tick_lo", 32'(frame_tick), 32'd0);
    if (!freeze) n_moves++;
    m_mode  = int'(mode);
    m_solid = solid_rgb;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
  endtask

  task automatic probe_box();
    int bx, by;
    bx = box_x();
    by = box_y();
    step(bx, by, 1, 1, 1);
    step(bx + 64, by, 1, 1, 1);
    step(bx + 63, by + 63, 1, 1, 1);
    step(bx, by + 64, 1, 1, 1);
    if (bx > 0) step(bx - 1, by, 1, 1, 1);
    if (by > 0) step(bx, by - 1, 1, 1, 1);
    step(0, 0, 0, 1, 1);
  endtask

  task automatic model_reset();
    n_moves = 0;
    m_mode  = 0;
    m_solid = 24'h0;
    hist.delete();
    hist.push_back(IDLE);
  endtask

  initial begin
    rst = 1'b1;
    xpix = 0; ypix = 0;
    disp_enable = 0; hsync_in = 1; vsync_in = 1;
    mode = 0; solid_rgb = 0; freeze = 0;

    // reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      xpix = $urandom(); ypix = $urandom();
      disp_enable = $urandom_range(0, 1);
      hsync_in = $urandom_range(0, 1);
      vsync_in = (i == 5) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("rst_out", 32'({vga_r, vga_g, vga_b, hsync_o, vsync_o, blank_n_o}),
          32'(IDLE));
      chk("rst_tick", 32'(frame_tick), 32'd0);
    end
    chk("sync_n", 32'(sync_n_o), 32'd0);
    #3 rst = 1'b0;
    model_reset();

    // bars on one full line, blanked gap after
    step(0, 5, 0, 0, 1);
    for (int x = 0; x < 1280; x++) step(x, 5, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(1280 + i, 5, 0, 0, 1);

    // checker
    mode = 1;
    frame();
    step(0, 0, 1, 1, 1);
    step(32, 0, 1, 1, 1);
    step(32, 32, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    step(31, 63, 1, 1, 1);
    step(0, 1, 0, 0, 1);

    // mode change mid-frame does not tear
    mode = 3;
    solid_rgb = 24'h123456;
    for (int i = 0; i < 8; i++) step(i * 17, i * 9, 1, 1, 1);
    frame();
    for (int i = 0; i < 8; i++) step(i * 17, i * 9, 1, 1, 1);
    chk("solid_r", 32'(vga_r), 32'h12);
    chk("solid_b", 32'(vga_b), 32'h56);

    // bouncing box over 400 frames
    mode = 2;
    for (int f = 0; f < 400; f++) begin
      frame();
      probe_box();
    end

    // freeze holds the box, then motion resumes
    freeze = 1;
    for (int f = 0; f < 3; f++) begin
      frame();
      probe_box();
    end
    freeze = 0;
    frame();
    probe_box();

    // random pixels in every mode
    for (int md = 0; md < 4; md++) begin
      mode = 2'(md);
      solid_rgb = 24'($urandom());
      frame();
      for (int i = 0; i < 150; i++)
        step($urandom_range(0, 1279), $urandom_range(0, 1023),
             ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1);
    end

    // async reset mid-line
    step(100, 100, 1, 1, 1);
    step(101, 100, 1, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst", 32'({vga_r, vga_g, vga_b, hsync_o, vsync_o, blank_n_o}),
        32'(IDLE));
    chk("mid_rst_tick", 32'(frame_tick), 32'd0);
    #2 rst = 1'b0;
    model_reset();
    step(5, 5, 1, 1, 1);
    mode = 2;
    for (int f = 0; f < 3; f++) begin
      frame();
      probe_box();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
